// File: rtl/extra_slot_arbiter.sv
// extra_slot_arbiter
//   Dynamic arbiter for the extra bus cycle (busCycle == 2'b10) of the
//   interleaved RAM schedule. Four requesters share the slot: audio, internal
//   floppy, external floppy and SCSI DMA read. Audio has bounded-wait
//   priority; the other three rotate round-robin.
//
//   Ports:
//     clk, _reset            system clock, synchronous active-low reset
//     clk8_en_p, busCycle    bus phase enable and 4-slot cycle index
//     sndReq/sndAddr         audio request and word address
//     dskReqInt/...AddrInt   internal floppy request and image offset
//     dskReqExt/...AddrExt   external floppy request and image offset
//     scsiReq/scsiAddr       SCSI DMA read request and address
//     extraAddr, extraRamOE  registered address / read enable for the slot
//     *ReadAck               registered one-hot grants, level for the slot
//     statGrant              {idle, scsi, dskExt, dskInt, snd} 16-bit
//                            saturating counters, only with the
//                            EXTRA_SLOT_STATS_EN macro defined
module extra_slot_arbiter #(
  parameter logic [21:0] DSK_INT_BASE   = 22'h100000,
  parameter logic [21:0] DSK_EXT_BASE   = 22'h200000,
  parameter logic [21:0] SCSI_BASE      = 22'h000000,
  parameter logic [1:0]  AUDIO_MAX_WAIT = 2'd2
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk8_en_p,
  input  logic [1:0]  busCycle,
  input  logic        sndReq,
  input  logic [21:0] sndAddr,
  input  logic        dskReqInt,
  input  logic [21:0] dskReadAddrInt,
  input  logic        dskReqExt,
  input  logic [21:0] dskReadAddrExt,
  input  logic        scsiReq,
  input  logic [21:0] scsiAddr,
  output logic [21:0] extraAddr,
  output logic        extraRamOE,
  output logic        sndReadAck,
  output logic        dskReadAckInt,
  output logic        dskReadAckExt,
  output logic        scsiReadAck
`ifdef EXTRA_SLOT_STATS_EN
  ,
  output logic [79:0] statGrant
`endif
);

  typedef enum logic [1:0] {
    RR_INT  = 2'd0,
    RR_EXT  = 2'd1,
    RR_SCSI = 2'd2
  } rr_ptr_t;

  rr_ptr_t     ptr_q, ptr_d;
  logic [1:0]  wait_q, wait_d;
  logic [3:0]  ack_q, ack_d;   // {scsi, dskExt, dskInt, snd}
  logic        oe_q, oe_d;
  logic [21:0] addr_q, addr_d;

  logic        decide, slot_end;
  logic [2:0]  rr_req, rr_win;  // {scsi, dskExt, dskInt}
  logic        rr_found, snd_win;
  logic [2:0]  idx_sum;

  always_comb begin
    decide   = clk8_en_p && (busCycle == 2'b01);
    slot_end = clk8_en_p && (busCycle == 2'b10);
    rr_req   = {scsiReq, dskReqExt, dskReqInt};
    snd_win  = sndReq && ((wait_q >= AUDIO_MAX_WAIT) || (rr_req == '0));

    // Scan the three rotating requesters starting at the pointer (mod 3).
    rr_win   = '0;
    rr_found = 1'b0;
    idx_sum  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx_sum = {1'b0, ptr_q} + 3'(i);
      if (idx_sum >= 3'd3) idx_sum = idx_sum - 3'd3;
      if (!rr_found && rr_req[idx_sum[1:0]]) begin
        rr_win[idx_sum[1:0]] = 1'b1;
        rr_found             = 1'b1;
      end
    end

    ptr_d  = ptr_q;
    wait_d = wait_q;
    ack_d  = ack_q;
    oe_d   = oe_q;
    addr_d = addr_q;

    if (slot_end) begin
      ack_d = '0;
      oe_d  = 1'b0;
    end

    if (decide) begin
      ack_d = '0;
      oe_d  = 1'b0;
      if (snd_win) begin
        ack_d  = 4'b0001;
        oe_d   = 1'b1;
        addr_d = sndAddr;
        wait_d = '0;
      end else begin
        // Idle slot keeps the previous address.
        if (rr_win[0]) begin
          ack_d  = 4'b0010;
          oe_d   = 1'b1;
          addr_d = dskReadAddrInt + DSK_INT_BASE;
          ptr_d  = RR_EXT;
        end else if (rr_win[1]) begin
          ack_d  = 4'b0100;
          oe_d   = 1'b1;
          addr_d = dskReadAddrExt + DSK_EXT_BASE;
          ptr_d  = RR_SCSI;
        end else if (rr_win[2]) begin
          ack_d  = 4'b1000;
          oe_d   = 1'b1;
          addr_d = scsiAddr + SCSI_BASE;
          ptr_d  = RR_INT;
        end
        if (!sndReq)                       wait_d = '0;
        else if (wait_q < AUDIO_MAX_WAIT)  wait_d = wait_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      ptr_q  <= RR_INT;
      wait_q <= '0;
      ack_q  <= '0;
      oe_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wait_q <= wait_d;
      ack_q  <= ack_d;
      oe_q   <= oe_d;
      addr_q <= addr_d;
    end
  end

  assign sndReadAck    = ack_q[0];
  assign dskReadAckInt = ack_q[1];
  assign dskReadAckExt = ack_q[2];
  assign scsiReadAck   = ack_q[3];
  assign extraRamOE    = oe_q;
  assign extraAddr     = addr_q;

`ifdef EXTRA_SLOT_STATS_EN
  logic [15:0] cnt_q [5];  // snd, dskInt, dskExt, scsi, idle
  logic [4:0]  stat_hit;

  always_comb begin
    stat_hit = '0;
    if (decide) stat_hit = {(ack_d == '0), ack_d};
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 5; k++) begin
      if (!_reset)                             cnt_q[k] <= '0;
      else if (stat_hit[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 16'd1;
    end
  end

  assign statGrant = {cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_extra_slot_arbiter.sv
// Testbench for extra_slot_arbiter: directed scenarios plus randomized
// requests, compared every clock against a slot-level behavioural model.
module tb_extra_slot_arbiter;

  localparam logic [21:0] INT_BASE  = 22'h100000;
  localparam logic [21:0] EXT_BASE  = 22'h200000;
  localparam logic [21:0] SCSI_BASE = 22'h000000;
  localparam int          MAXW      = 2;

  logic        clk = 1'b0;
  logic        _reset = 1'b0;
  logic        clk8_en_p = 1'b0;
  logic [1:0]  busCycle = 2'b00;
  logic        sndReq = 1'b0, dskReqInt = 1'b0, dskReqExt = 1'b0, scsiReq = 1'b0;
  logic [21:0] sndAddr = '0, dskReadAddrInt = '0, dskReadAddrExt = '0, scsiAddr = '0;
  logic [21:0] extraAddr;
  logic        extraRamOE, sndReadAck, dskReadAckInt, dskReadAckExt, scsiReadAck;
`ifdef EXTRA_SLOT_STATS_EN
  logic [79:0] statGrant;
`endif

  extra_slot_arbiter #(
    .DSK_INT_BASE(INT_BASE),
    .DSK_EXT_BASE(EXT_BASE),
    .SCSI_BASE(SCSI_BASE),
    .AUDIO_MAX_WAIT(2'd2)
  ) dut (
    .clk(clk), ._reset(_reset), .clk8_en_p(clk8_en_p), .busCycle(busCycle),
    .sndReq(sndReq), .sndAddr(sndAddr),
    .dskReqInt(dskReqInt), .dskReadAddrInt(dskReadAddrInt),
    .dskReqExt(dskReqExt), .dskReadAddrExt(dskReadAddrExt),
    .scsiReq(scsiReq), .scsiAddr(scsiAddr),
    .extraAddr(extraAddr), .extraRamOE(extraRamOE),
    .sndReadAck(sndReadAck), .dskReadAckInt(dskReadAckInt),
    .dskReadAckExt(dskReadAckExt), .scsiReadAck(scsiReadAck)
`ifdef EXTRA_SLOT_STATS_EN
    , .statGrant(statGrant)
`endif
  );

  always #5 clk = ~clk;

  // Bus timing: 4 clk per busCycle value, clk8_en_p on the last of the four.
  int phase = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      if (phase == 0) busCycle = busCycle + 2'd1;
      clk8_en_p = (phase == 3);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Behavioural model: one decision per slot; winner code -1 none,
  // 0 snd, 1 dskInt, 2 dskExt, 3 scsi. Rotation pointer counts 0..2.
  int          m_win = -1, m_ptr = 0, m_wait = 0;
  logic [21:0] m_addr = '0;
  int          m_rq [3];
  logic [21:0] m_ra [3];
  int          m_c;
  bit          m_found;

  always @(posedge clk) begin
    if (!_reset) begin
      m_win = -1; m_ptr = 0; m_wait = 0; m_addr = '0;
    end else if (clk8_en_p && busCycle == 2'b01) begin
      m_rq[0] = dskReqInt; m_rq[1] = dskReqExt; m_rq[2] = scsiReq;
      m_ra[0] = dskReadAddrInt + INT_BASE;
      m_ra[1] = dskReadAddrExt + EXT_BASE;
      m_ra[2] = scsiAddr + SCSI_BASE;
      if (sndReq && (m_wait >= MAXW || (m_rq[0] + m_rq[1] + m_rq[2]) == 0)) begin
        m_win = 0; m_addr = sndAddr; m_wait = 0;
      end else begin
        m_win = -1; m_found = 0;
        for (int k = 0; k < 3; k++) begin
          m_c = (m_ptr + k) % 3;
          if (!m_found && m_rq[m_c] != 0) begin
            m_found = 1; m_win = m_c + 1; m_addr = m_ra[m_c];
          end
        end
        if (m_found) m_ptr = m_win % 3;
        m_wait = sndReq ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
      end
    end else if (clk8_en_p && busCycle == 2'b10) begin
      m_win = -1;
    end
  end

  // Per-cycle compare plus a log of DUT grants (code, address, OE, length).
  int          g_code[$];
  logic [21:0] g_addr[$];
  logic        g_oe[$];
  int          g_len[$];
  logic [3:0]  prev_ack = '0;
  logic [3:0]  dut_ack, exp_ack;

  always @(negedge clk) begin
    dut_ack = {scsiReadAck, dskReadAckExt, dskReadAckInt, sndReadAck};
    exp_ack = (m_win >= 0) ? 4'(1 << m_win) : 4'b0000;
    check("cycle", {37'd0, dut_ack, extraRamOE, extraAddr},
                   {37'd0, exp_ack, (m_win >= 0), m_addr});
    if (dut_ack != 0 && dut_ack != prev_ack) begin
      g_code.push_back(dut_ack[0] ? 0 : dut_ack[1] ? 1 : dut_ack[2] ? 2 : 3);
      g_addr.push_back(extraAddr);
      g_oe.push_back(extraRamOE);
      g_len.push_back(1);
    end else if (dut_ack != 0) begin
      g_len[g_len.size() - 1]++;
    end
    prev_ack = dut_ack;
  end

  task automatic clear_log();
    g_code.delete(); g_addr.delete(); g_oe.delete(); g_len.delete();
  endtask

  // Returns 2 time units after a decision edge.
  task automatic wait_decision();
    int b = 0;
    do begin
      @(posedge clk);
      b++;
    end while (!(clk8_en_p && busCycle == 2'b01) && b < 40);
    if (b >= 40) begin
      n_checks++;
      $display("FAIL decision_wait: got no decision point within %0d clk, required one", b);
    end
    #2;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    _reset = 1'b0;
    sndReq = 0; dskReqInt = 0; dskReqExt = 0; scsiReq = 0;
    repeat (2) @(posedge clk);
    #1 _reset = 1'b1;
    clear_log();
  endtask

  // seq holds the expected codes as hex nibbles, first grant most significant.
  task automatic check_log(input string name, input int n, input logic [23:0] seq);
    check($sformatf("%s_count", name), 64'(g_code.size()), 64'(n));
    for (int k = 0; k < n && k < g_code.size(); k++) begin
      check($sformatf("%s_grant%0d", name, k), 64'(g_code[k]), 64'(seq[4*(n-1-k) +: 4]));
      check($sformatf("%s_len%0d", name, k), 64'(g_len[k]), 64'd4);
      check($sformatf("%s_oe%0d", name, k), 64'(g_oe[k]), 64'd1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across a decision point with every request high.
    sndReq = 1; dskReqInt = 1; dskReqExt = 1; scsiReq = 1;
    wait_decision();
    wait_decision();
    check("reset_state", {37'd0, sndReadAck, dskReadAckInt, dskReadAckExt, scsiReadAck,
                          extraRamOE, extraAddr}, 64'd0);
    _reset = 1'b1;
    clear_log();
    repeat (3) wait_decision();
    settle();
    check_log("rst_release", 3, 24'h120);

    // Lone internal floppy request.
    do_reset();
    dskReqInt = 1; dskReadAddrInt = 22'h000123;
    wait_decision();
    dskReqInt = 0;
    settle();
    check_log("int_only", 1, 24'h1);
    if (g_addr.size() > 0) check("int_only_addr", 64'(g_addr[0]), 64'h100123);

    // Three rotating requesters held high.
    do_reset();
    dskReqInt = 1; dskReqExt = 1; scsiReq = 1;
    repeat (4) wait_decision();
    settle();
    check_log("rr3", 4, 24'h1231);

    // All four held high: audio wins after two losses.
    do_reset();
    sndReq = 1; dskReqInt = 1; dskReqExt = 1; scsiReq = 1;
    repeat (6) wait_decision();
    sndReq = 0; dskReqInt = 0; dskReqExt = 0; scsiReq = 0;
    settle();
    check_log("all4", 6, 24'h120310);

    // External floppy address wraps modulo 2^22.
    do_reset();
    dskReqExt = 1; dskReadAddrExt = 22'h3FFFFE;
    wait_decision();
    dskReqExt = 0;
    settle();
    check_log("ext_wrap", 1, 24'h2);
    if (g_addr.size() > 0) check("ext_wrap_addr", 64'(g_addr[0]), 64'h1FFFFE);

    // Reset pulse mid-slot drops the grant and rewinds the pointer.
    do_reset();
    dskReqInt = 1; dskReadAddrInt = 22'h000040;
    wait_decision();
    dskReqInt = 0;
    @(posedge clk); #1 _reset = 1'b0;
    @(posedge clk); #1 _reset = 1'b1;
    @(negedge clk);
    check("midslot_reset", {60'd0, sndReadAck, dskReadAckInt, dskReadAckExt, extraRamOE}, 64'd0);
    clear_log();
    dskReqInt = 1; dskReqExt = 1;
    wait_decision();
    dskReqInt = 0; dskReqExt = 0;
    settle();
    check_log("ptr_rewind", 1, 24'h1);

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int s = 0; s < 250; s++) begin
      sndReq    = ($urandom_range(0, 3) != 0);
      dskReqInt = ($urandom_range(0, 1) != 0);
      dskReqExt = ($urandom_range(0, 1) != 0);
      scsiReq   = ($urandom_range(0, 2) == 0);
      sndAddr        = 22'($urandom);
      dskReadAddrInt = 22'($urandom);
      dskReadAddrExt = 22'($urandom);
      scsiAddr       = 22'($urandom);
      wait_decision();
      if (s % 17 == 0) begin
        sndReq = 0; dskReqInt = 0; dskReqExt = 0; scsiReq = 0;
        wait_decision();
      end
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
